multicycle_control: RTL

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/mips_pkg.sv | 57 +++++
 rtl/multicycle_control_if.sv | 36 +++
 rtl/mc_output_decode.sv | 70 +++++++
 rtl/multicycle_control.sv | 80 ++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS encodings: opcodes, multicycle state codes, ALU/mux selects
// and the control word bundle driven by the multicycle controller.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LI    = 6'b100111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       iord;
    logic       pc_write;
    logic       branch;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Controller-to-datapath bundle: opcode/mem_ready in, control strobes out.
interface multicycle_control_if;

  logic [5:0] opcode;
  logic       mem_ready;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       iord;
  logic       pc_write;
  logic       branch;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_src;
  logic [3:0] state;
  logic       illegal;

  modport master (
    input  opcode, mem_ready,
    output mem_read, mem_write, ir_write, iord, pc_write, branch,
           reg_write, reg_dst, mem_to_reg, alu_src_a,
           alu_src_b, alu_op, pc_src, state, illegal
  );

  modport slave (
    output opcode, mem_ready,
    input  mem_read, mem_write, ir_write, iord, pc_write, branch,
           reg_write, reg_dst, mem_to_reg, alu_src_a,
           alu_src_b, alu_op, pc_src, state, illegal
  );

endinterface

// File: rtl/mc_output_decode.sv
// Moore output decode for the multicycle controller; only the FETCH
// IR/PC load strobes look at mem_ready.
module mc_output_decode
  import mips_pkg::*;
(
  input  state_t   state,
  input  logic     mem_ready,
  output ctrl_t    ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_src    = PCSRC_ALU;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEMADR, S_IEXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_RT;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_RT;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_src    = PCSRC_ALUOUT;
        ctrl.branch    = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PCSRC_JUMP;
      end
      S_IWB: begin
        ctrl.reg_write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: state register and next-state logic here,
// per-state output decode in mc_output_decode.
module multicycle_control
  import mips_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  multicycle_control_if.master   bus
);

  state_t state_q;
  state_t state_d;
  logic   illegal_d;
  ctrl_t  ctrl;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  // Opcode is only looked at in DECODE and MEMADR; mem_ready only in the
  // three memory-wait states.
  always_comb begin
    state_d   = S_FETCH;
    illegal_d = 1'b0;
    case (state_q)
      S_FETCH:  state_d = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.opcode)
          OP_RTYPE:       state_d = S_EXEC;
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_BEQ:         state_d = S_BRANCH;
          OP_J:           state_d = S_JUMP;
          OP_ADDI, OP_LI: state_d = S_IEXEC;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = bus.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = bus.mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_IEXEC:  state_d = S_IWB;
      S_IWB:    state_d = S_FETCH;
      default: begin
        state_d   = S_FETCH;
        illegal_d = 1'b1;
      end
    endcase
  end

  mc_output_decode u_decode (
    .state     (state_q),
    .mem_ready (bus.mem_ready),
    .ctrl      (ctrl)
  );

  assign bus.mem_read   = ctrl.mem_read;
  assign bus.mem_write  = ctrl.mem_write;
  assign bus.ir_write   = ctrl.ir_write;
  assign bus.iord       = ctrl.iord;
  assign bus.pc_write   = ctrl.pc_write;
  assign bus.branch     = ctrl.branch;
  assign bus.reg_write  = ctrl.reg_write;
  assign bus.reg_dst    = ctrl.reg_dst;
  assign bus.mem_to_reg = ctrl.mem_to_reg;
  assign bus.alu_src_a  = ctrl.alu_src_a;
  assign bus.alu_src_b  = ctrl.alu_src_b;
  assign bus.alu_op     = ctrl.alu_op;
  assign bus.pc_src     = ctrl.pc_src;
  assign bus.state      = state_q;
  assign bus.illegal    = illegal_d;

endmodule
